// File: rtl/bomb_controller.sv
// Per-frame projectile engine: launches a bomb, integrates ballistic motion once per
// video frame, detects terrain/floor impact and times the explosion.
`timescale 1ns/1ps
module bomb_controller #(
    parameter int BOMB_SIZE      = 4,
    parameter int EXPLODE_SIZE   = 16,
    parameter int EXPLODE_FRAMES = 30,
    parameter int GRAVITY        = 1,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] PX,
    input  logic [9:0] PY,
    input  logic [9:0] launch_vx,
    input  logic [9:0] launch_vy,
    input  logic       terrain_hit,
    output logic [9:0] BX,
    output logic [9:0] BY,
    output logic [9:0] BS,
    output logic       busy,
    output logic       crater_req
);

    typedef enum logic [1:0] {IDLE, FLIGHT, EXPLODE} state_t;

    localparam int CW = $clog2(EXPLODE_FRAMES + 1);

    state_t             state, state_n;
    logic signed [10:0] x, x_n;
    logic signed [11:0] y, y_n;
    logic signed [9:0]  vx, vx_n, vy, vy_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               frame_clk_d, tick, crater_n;
    logic signed [11:0] x_sum;
    logic signed [12:0] y_sum;
    logic signed [10:0] vy_sum;

    assign tick = frame_clk & ~frame_clk_d;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            vx          <= '0;
            vy          <= '0;
            cnt         <= '0;
            frame_clk_d <= 1'b0;
            crater_req  <= 1'b0;
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            vx          <= vx_n;
            vy          <= vy_n;
            cnt         <= cnt_n;
            frame_clk_d <= frame_clk;
            crater_req  <= crater_n;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        vx_n     = vx;
        vy_n     = vy;
        cnt_n    = cnt;
        crater_n = 1'b0;
        // Sums are one bit wider than the position so the bounds tests see no wrap
        x_sum    = {x[10], x} + {{2{vx[9]}}, vx};
        y_sum    = {y[11], y} + {{3{vy[9]}}, vy};
        vy_sum   = {vy[9], vy} + 11'(GRAVITY);
        if (tick) begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        x_n     = {1'b0, PX};
                        y_n     = {2'b00, PY};
                        vx_n    = launch_vx;
                        vy_n    = launch_vy;
                        state_n = FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (terrain_hit) begin
                        state_n  = EXPLODE;
                        cnt_n    = '0;
                        crater_n = 1'b1;
                    end else begin
                        if (vy_sum > 11'sd511)
                            vy_n = 10'h1FF;
                        else if (vy_sum < -11'sd512)
                            vy_n = 10'h200;
                        else
                            vy_n = vy_sum[9:0];
                        if (x_sum < 0 || x_sum > X_MAX) begin
                            state_n = IDLE;
                        end else if (y_sum > Y_MAX) begin
                            x_n      = x_sum[10:0];
                            y_n      = 12'(Y_MAX);
                            state_n  = EXPLODE;
                            cnt_n    = '0;
                            crater_n = 1'b1;
                        end else begin
                            x_n = x_sum[10:0];
                            y_n = y_sum[11:0];
                        end
                    end
                end
                EXPLODE: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(EXPLODE_FRAMES - 1))
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A bomb above the top edge keeps flying but is not drawn
    always_comb begin
        BX   = x[9:0];
        BY   = y[11] ? '0 : y[9:0];
        BS   = '0;
        busy = 1'b0;
        case (state)
            FLIGHT: begin
                busy = 1'b1;
                if (!y[11])
                    BS = 10'(BOMB_SIZE);
            end
            EXPLODE: begin
                busy = 1'b1;
                BS   = 10'(EXPLODE_SIZE);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: directed scenarios plus randomized flights, all checked
// against a frame-level behavioural model of the projectile.
`timescale 1ns/1ps
module tb_bomb_controller;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] PX = '0, PY = '0, launch_vx = '0, launch_vy = '0;
    logic       terrain_hit = 1'b0;
    logic [9:0] BX, BY, BS;
    logic       busy, crater_req;

    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 flying, 2 exploding
    int m_state, mx, my, mvx, mvy, mcnt, mcrater;

    bomb_controller #(
        .BOMB_SIZE(4), .EXPLODE_SIZE(16), .EXPLODE_FRAMES(30),
        .GRAVITY(1), .X_MAX(639), .Y_MAX(479)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
        .PX(PX), .PY(PY), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .terrain_hit(terrain_hit), .BX(BX), .BY(BY), .BS(BS),
        .busy(busy), .crater_req(crater_req)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exhausted got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap12(input int v);
        int r;
        r = v & 32'hFFF;
        if (r >= 2048) r -= 4096;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; mx = 0; my = 0; mvx = 0; mvy = 0; mcnt = 0; mcrater = 0;
    endtask

    task automatic model_tick();
        int nx, ny;
        mcrater = 0;
        case (m_state)
            0: if (fire) begin
                mx = int'(PX); my = int'(PY);
                mvx = int'($signed(launch_vx)); mvy = int'($signed(launch_vy));
                m_state = 1;
            end
            1: if (terrain_hit) begin
                m_state = 2; mcnt = 0; mcrater = 1;
            end else begin
                nx = mx + mvx;
                ny = my + mvy;
                mvy = (mvy + 1 > 511) ? 511 : mvy + 1;
                if (nx < 0 || nx > 639) m_state = 0;
                else if (ny > 479) begin
                    mx = nx; my = 479; m_state = 2; mcnt = 0; mcrater = 1;
                end else begin
                    mx = nx; my = wrap12(ny);
                end
            end
            default: begin
                if (mcnt == 29) m_state = 0;
                mcnt++;
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        int ebs;
        ebs = (m_state == 1) ? ((my < 0) ? 0 : 4) : (m_state == 2) ? 16 : 0;
        check({tag, "_bx"}, int'(BX), mx & 1023);
        check({tag, "_by"}, int'(BY), (my < 0) ? 0 : (my & 1023));
        check({tag, "_bs"}, int'(BS), ebs);
        check({tag, "_busy"}, int'(busy), (m_state != 0) ? 1 : 0);
        check({tag, "_crater"}, int'(crater_req), mcrater);
    endtask

    // One frame strobe held for 'hold' Clk cycles; every cycle is checked
    task automatic frame(input int hold, input string tag);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);
        model_tick();
        #1;
        check_outputs(tag);
        mcrater = 0;
        for (int i = 1; i < hold; i++) begin
            @(posedge Clk); #1;
            check_outputs(tag);
        end
        @(negedge Clk);
        frame_clk = 1'b0;
        @(posedge Clk); #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        model_reset();
        #1;
        check_outputs("rst");
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic set_launch(input int px, input int py, input int vx, input int vy);
        PX = 10'(px); PY = 10'(py); launch_vx = 10'(vx); launch_vy = 10'(vy);
    endtask

    initial begin
        int hidden_seen, reappear_seen;
        model_reset();
        do_reset();

        // reset mid-flight, then no activity without a frame strobe
        set_launch(200, 300, 2, -3); fire = 1'b1;
        frame(1, "t1_launch");
        frame(1, "t1_fly");
        do_reset();
        check("t1_bs_zero", int'(BS), 0);
        check("t1_busy_zero", int'(busy), 0);
        repeat (4) @(posedge Clk);
        #1;
        check_outputs("t1_quiet");

        // straight-line trajectory with hand-computed positions
        set_launch(100, 200, 3, -4); fire = 1'b1;
        frame(1, "t2_launch");
        check("t2_l_bx", int'(BX), 100); check("t2_l_by", int'(BY), 200); check("t2_l_bs", int'(BS), 4);
        fire = 1'b0;
        frame(1, "t2_f1"); check("t2_f1_bx", int'(BX), 103); check("t2_f1_by", int'(BY), 196);
        frame(1, "t2_f2"); check("t2_f2_bx", int'(BX), 106); check("t2_f2_by", int'(BY), 193);
        frame(1, "t2_f3"); check("t2_f3_bx", int'(BX), 109); check("t2_f3_by", int'(BY), 191);
        frame(5, "t2_hold"); check("t2_hold_bx", int'(BX), 112); check("t2_hold_by", int'(BY), 190);

        // leaving the right edge returns to idle without a crater
        do_reset();
        set_launch(630, 100, 5, 0); fire = 1'b1;
        frame(1, "t3_launch");
        fire = 1'b0;
        frame(1, "t3_f1"); check("t3_bx_635", int'(BX), 635);
        frame(1, "t3_exit"); check("t3_bs_off", int'(BS), 0); check("t3_idle", int'(busy), 0);

        // terrain impact and full explosion
        do_reset();
        set_launch(300, 100, 2, 0); fire = 1'b1;
        frame(1, "t4_launch");
        fire = 1'b0;
        frame(1, "t4_f1");
        frame(1, "t4_f2");
        terrain_hit = 1'b1;
        frame(1, "t4_hit");
        check("t4_hit_bx", int'(BX), 304); check("t4_hit_bs", int'(BS), 16);
        terrain_hit = 1'b0;
        for (int i = 0; i < 29; i++) frame(1, "t4_boom");
        check("t4_boom_bs", int'(BS), 16);
        frame(1, "t4_end");
        check("t4_end_bs", int'(BS), 0); check("t4_end_busy", int'(busy), 0);

        // floor clamp
        do_reset();
        set_launch(50, 470, 0, 8); fire = 1'b1;
        frame(1, "t5_launch");
        fire = 1'b0;
        frame(1, "t5_f1"); check("t5_by_478", int'(BY), 478);
        frame(1, "t5_floor"); check("t5_by_479", int'(BY), 479); check("t5_bs16", int'(BS), 16);
        for (int i = 0; i < 30; i++) frame(1, "t5_boom");

        // high lob off the top, fire toggling in flight, fire held through explode end
        do_reset();
        set_launch(100, 100, 1, -30); fire = 1'b1;
        frame(1, "t6_launch");
        hidden_seen = 0; reappear_seen = 0;
        for (int f = 0; f < 200 && m_state != 0; f++) begin
            fire = (m_state == 2) ? 1'b1 : 1'(f & 1);
            frame(1, "t6_fly");
            if (busy && BS == 0) hidden_seen = 1;
            if (hidden_seen == 1 && BS == 4) reappear_seen = 1;
        end
        check("t6_hidden", hidden_seen, 1);
        check("t6_reappear", reappear_seen, 1);
        check("t6_end_idle", int'(busy), 0);
        frame(1, "t6_relaunch");
        check("t6_relaunch_busy", int'(busy), 1);
        check("t6_relaunch_bx", int'(BX), 100);
        check("t6_relaunch_bs", int'(BS), 4);

        // randomized flights
        for (int run = 0; run < 20; run++) begin
            do_reset();
            set_launch(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                       int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 60)) - 40);
            fire = 1'b1;
            frame(1, "rnd_launch");
            for (int f = 0; f < 120; f++) begin
                fire = ($urandom_range(0, 3) == 0);
                terrain_hit = (m_state == 1) && ($urandom_range(0, 24) == 0);
                if (m_state == 0 && fire)
                    set_launch(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                               int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 60)) - 40);
                frame(int'($urandom_range(1, 3)), "rnd");
                terrain_hit = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
